// File: rtl/ci_sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer: machine-cycle phase
// encodings, microcode continuation bit position and a phase decode helper.
package ci_sequencer_pkg;

  // Six machine-cycle phases plus the instruction-boundary halt state
  typedef enum logic [2:0] {
    ST_S1   = 3'd0,
    ST_S2   = 3'd1,
    ST_S3   = 3'd2,
    ST_S4   = 3'd3,
    ST_S5   = 3'd4,
    ST_S6   = 3'd5,
    ST_HALT = 3'd6
  } phase_t;

  // The parent connects i_mc_cont to bit MC_CONT_BIT of the microcode word
  localparam int MCODE_WIDTH = 32;
  localparam int MC_CONT_BIT = MCODE_WIDTH - 1;

  // One-hot position of an S-state; ST_HALT has no tick position
  function automatic logic [5:0] phase_onehot(input phase_t st);
    logic [5:0] oh;
    case (st)
      ST_S1:   oh = 6'b000001;
      ST_S2:   oh = 6'b000010;
      ST_S3:   oh = 6'b000100;
      ST_S4:   oh = 6'b001000;
      ST_S5:   oh = 6'b010000;
      ST_S6:   oh = 6'b100000;
      default: oh = 6'b000000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/ci_sequencer.sv
// Instruction-cycle sequencer: fetches the opcode in S1, steps S1..S6 and
// advances the ci_stage counter when the microcode asks for a continuation.
// Ticks, instr_done and stage_err are combinational so the decoder sees them
// in the same cycle the state register is about to advance.
module ci_sequencer
  import ci_sequencer_pkg::*;
#(
  parameter int         MAX_STAGE    = 3,
  parameter logic [7:0] RESET_OPCODE = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_mc_cont,
  input  logic       i_state_ready,
  input  logic [7:0] i_op_byte,
  input  logic       i_op_valid,
  input  logic       i_halt,
  output logic [7:0] o_instr_buffer,
  output logic [1:0] o_ci_stage,
  output logic [5:0] o_s_done_tick,
  output logic       o_fetch_req,
  output logic       o_instr_done,
  output logic       o_stage_err
);

  localparam logic [1:0] MAX_STAGE_C = 2'(MAX_STAGE);

  phase_t     state_r, state_nxt_s;
  logic       fetch_pend_r, fetch_pend_nxt_s;
  logic [1:0] stage_r, stage_nxt_s;
  logic [7:0] buf_r, buf_nxt_s;
  logic       fetch_s1_s;
  logic       complete_s;
  logic       done_s;
  logic       err_s;

  // State, fetch flag, stage counter and instruction buffer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_S1;
      fetch_pend_r <= 1'b1;
      stage_r      <= 2'd0;
      buf_r        <= RESET_OPCODE;
    end else begin
      state_r      <= state_nxt_s;
      fetch_pend_r <= fetch_pend_nxt_s;
      stage_r      <= stage_nxt_s;
      buf_r        <= buf_nxt_s;
    end
  end

  // Completion condition, next-state decode and boundary handling
  always_comb begin
    state_nxt_s      = state_r;
    fetch_pend_nxt_s = fetch_pend_r;
    stage_nxt_s      = stage_r;
    buf_nxt_s        = buf_r;
    done_s           = 1'b0;
    err_s            = 1'b0;
    fetch_s1_s       = (state_r == ST_S1) && fetch_pend_r;
    // a fetching S1 additionally needs the opcode byte to be on the bus
    complete_s       = (state_r != ST_HALT) && i_state_ready && (!fetch_s1_s || i_op_valid);

    case (state_r)
      ST_S1: begin
        if (complete_s) begin
          state_nxt_s = ST_S2;
          if (fetch_pend_r) begin
            buf_nxt_s        = i_op_byte;
            fetch_pend_nxt_s = 1'b0;
          end else begin
            buf_nxt_s = buf_r;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_S2: begin
        if (complete_s) state_nxt_s = ST_S3;
        else            state_nxt_s = state_r;
      end
      ST_S3: begin
        if (complete_s) state_nxt_s = ST_S4;
        else            state_nxt_s = state_r;
      end
      ST_S4: begin
        if (complete_s) state_nxt_s = ST_S5;
        else            state_nxt_s = state_r;
      end
      ST_S5: begin
        if (complete_s) state_nxt_s = ST_S6;
        else            state_nxt_s = state_r;
      end
      ST_S6: begin
        if (complete_s) begin
          if (i_mc_cont && (stage_r < MAX_STAGE_C)) begin
            // continuation: same opcode, next stage, no refetch
            stage_nxt_s = stage_r + 2'd1;
            state_nxt_s = ST_S1;
          end else begin
            // end of instruction; a continuation at the last stage is an error
            done_s           = 1'b1;
            err_s            = i_mc_cont;
            stage_nxt_s      = 2'd0;
            fetch_pend_nxt_s = 1'b1;
            if (i_halt) state_nxt_s = ST_HALT;
            else        state_nxt_s = ST_S1;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_HALT: begin
        if (!i_halt) begin
          state_nxt_s      = ST_S1;
          fetch_pend_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s      = ST_S1;
        fetch_pend_nxt_s = 1'b1;
        stage_nxt_s      = 2'd0;
      end
    endcase
  end

  assign o_instr_buffer = buf_r;
  assign o_ci_stage     = stage_r;
  assign o_fetch_req    = fetch_s1_s;
  assign o_s_done_tick  = complete_s ? phase_onehot(state_r) : 6'b000000;
  assign o_instr_done   = done_s;
  assign o_stage_err    = err_s;

endmodule

// File: tb/tb_ci_sequencer.sv
// Scoreboard bench for ci_sequencer: the stimulus process pushes one expected
// record per predicted state tick; the monitor pops and compares each time the
// DUT raises a tick.
module tb_ci_sequencer;

  typedef struct {
    logic [5:0] tick;
    logic [1:0] stage;
    logic [7:0] buf_v;
    logic       fetch;
    logic       done;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       mc_cont;
  logic       state_ready;
  logic [7:0] op_byte;
  logic       op_valid;
  logic       halt;
  logic [7:0] instr_buffer;
  logic [1:0] ci_stage;
  logic [5:0] s_done_tick;
  logic       fetch_req;
  logic       instr_done;
  logic       stage_err;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] cur_buf;

  ci_sequencer #(.MAX_STAGE(3), .RESET_OPCODE(8'h00)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_mc_cont     (mc_cont),
    .i_state_ready (state_ready),
    .i_op_byte     (op_byte),
    .i_op_valid    (op_valid),
    .i_halt        (halt),
    .o_instr_buffer(instr_buffer),
    .o_ci_stage    (ci_stage),
    .o_s_done_tick (s_done_tick),
    .o_fetch_req   (fetch_req),
    .o_instr_done  (instr_done),
    .o_stage_err   (stage_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every tick against the oldest expected record
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (s_done_tick !== 6'b000000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tick", {26'd0, s_done_tick}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("tick", {26'd0, s_done_tick}, {26'd0, e.tick});
          chk("stage", {30'd0, ci_stage}, {30'd0, e.stage});
          chk("buffer", {24'd0, instr_buffer}, {24'd0, e.buf_v});
          chk("fetch_req", {31'd0, fetch_req}, {31'd0, e.fetch});
          chk("instr_done", {31'd0, instr_done}, {31'd0, e.done});
          chk("stage_err", {31'd0, stage_err}, {31'd0, e.err});
        end
      end else begin
        chk("idle_done_err", {30'd0, instr_done, stage_err}, 32'd0);
      end
    end
  end

  // Drive one instruction from a fetching S1. n_cont = number of stages that
  // request continuation (>3 means an error at stage 3). abort_at = stage*6+k
  // asserts reset just before that state instead of running it.
  task automatic run_instr(input logic [7:0] op, input int n_cont, input int s2_wait,
                           input bit halt_s3, input int abort_at);
    int last;
    last = (n_cont > 3) ? 3 : n_cont;
    for (int s = 0; s <= last; s++) begin
      for (int k = 0; k < 6; k++) begin
        exp_t e;
        if (abort_at == s * 6 + k) begin
          rst_n = 1'b0;
          #1;
          chk("async_rst_fetch", {31'd0, fetch_req}, 32'd1);
          chk("async_rst_buf", {24'd0, instr_buffer}, 32'h00);
          chk("async_rst_stage", {30'd0, ci_stage}, 32'd0);
          chk("async_rst_tick", {26'd0, s_done_tick}, 32'd0);
          cur_buf = 8'h00;
          return;
        end
        if (k == 2 && halt_s3) halt = 1'b1;
        if (k == 1 && s == 0) begin
          for (int w = 0; w < s2_wait; w++) begin
            state_ready = 1'b0;
            @(posedge clk); #1;
          end
        end
        state_ready = 1'b1;
        op_valid    = (k == 0 && s == 0);
        op_byte     = (k == 0 && s == 0) ? op : 8'hEE;
        mc_cont     = (k == 5) ? (s < n_cont) : !(s < n_cont);
        e.tick  = 6'(1 << k);
        e.stage = 2'(s);
        e.buf_v = (k == 0 && s == 0) ? cur_buf : op;
        e.fetch = (k == 0 && s == 0);
        e.done  = (k == 5 && s == last);
        e.err   = (k == 5 && s == 3 && n_cont > 3);
        exp_q.push_back(e);
        @(posedge clk); #1;
      end
    end
    cur_buf = op;
  endtask

  initial begin
    rst_n = 1'b0; mc_cont = 1'b0; state_ready = 1'b0; op_byte = 8'h00;
    op_valid = 1'b0; halt = 1'b0; cur_buf = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Reset state with valid held low: waiting in fetch, no ticks
    state_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_fetch_req", {31'd0, fetch_req}, 32'd1);
      chk("rst_buf", {24'd0, instr_buffer}, 32'h00);
      chk("rst_stage", {30'd0, ci_stage}, 32'd0);
      chk("rst_tick", {26'd0, s_done_tick}, 32'd0);
      @(posedge clk); #1;
    end
    run_instr(8'h00, 0, 0, 1'b0, -1);
    chk("fetch_after_done", {31'd0, fetch_req}, 32'd1);
    run_instr(8'h88, 1, 0, 1'b0, -1);
    run_instr(8'h3C, 0, 3, 1'b0, -1);
    run_instr(8'hA5, 4, 0, 1'b0, -1);
    chk("fetch_after_err", {31'd0, fetch_req}, 32'd1);
    chk("stage_after_err", {30'd0, ci_stage}, 32'd0);
    // Reset during S4 of stage 1
    run_instr(8'h5A, 1, 0, 1'b0, 6 + 3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_fetch", {31'd0, fetch_req}, 32'd1);
    run_instr(8'h77, 0, 0, 1'b0, -1);
    // Halt raised in S3: finish, then sit idle
    run_instr(8'h12, 0, 0, 1'b1, -1);
    op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("halt_no_fetch", {31'd0, fetch_req}, 32'd0);
      @(posedge clk); #1;
    end
    halt = 1'b0;
    @(posedge clk); #1;
    chk("unhalt_fetch", {31'd0, fetch_req}, 32'd1);
    run_instr(8'hC3, 2, 0, 1'b0, -1);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
